// File: rtl/rpsc_input_filter_if.sv
// Signal bundle between the RPSC field-input filter and the card logic.
// Optional glitch-counter signals exist only when RPSC_FILT_GLITCH_CNT_EN is defined.
interface rpsc_input_filter_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]   raw_in;
   logic [N_CH-1:0]   filt_out;
   logic [N_CH-1:0]   rise_pulse;
   logic [N_CH-1:0]   fall_pulse;
   logic [N_CH-1:0]   fault_latch;
   logic [N_CH-1:0]   fault_ack;
`ifdef RPSC_FILT_GLITCH_CNT_EN
   logic              glitch_clr;
   logic [8*N_CH-1:0] glitch_cnt;

   modport master (
      output raw_in, fault_ack, glitch_clr,
      input  filt_out, rise_pulse, fall_pulse, fault_latch, glitch_cnt
   );
   modport slave (
      input  raw_in, fault_ack, glitch_clr,
      output filt_out, rise_pulse, fall_pulse, fault_latch, glitch_cnt
   );
`else
   modport master (
      output raw_in, fault_ack,
      input  filt_out, rise_pulse, fall_pulse, fault_latch
   );
   modport slave (
      input  raw_in, fault_ack,
      output filt_out, rise_pulse, fall_pulse, fault_latch
   );
`endif
endinterface

// File: rtl/rpsc_input_filter.sv
// Per-channel synchroniser, saturating integrator with hysteresis, edge pulses and sticky fault latch.
// Define RPSC_FILT_GLITCH_CNT_EN to add the per-channel 8-bit glitch counters.
module rpsc_input_filter #(
   parameter int              N_CH        = 4,
   parameter int              CNT_W       = 16,
   parameter int              FILT_CYCLES = 781,
   parameter logic [N_CH-1:0] LATCH_MASK  = {N_CH{1'b0}}
) (
   input logic                clk,
   input logic                reset,
   rpsc_input_filter_if.slave flt_io
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FILT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [N_CH-1:0]  s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]  filt_q, filt_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  fall_q, fall_d;
   logic [N_CH-1:0]  latch_q, latch_d;

   // Integrator and hysteresis: level flips only when the count reaches either rail.
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         cnt_d[c]  = cnt_q[c];
         filt_d[c] = filt_q[c];
         if (s2_q[c] && (cnt_q[c] < CNT_FULL)) begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
         end else if (!s2_q[c] && (cnt_q[c] > CNT_ZERO)) begin
            cnt_d[c] = cnt_q[c] - CNT_ONE;
         end else begin
            cnt_d[c] = cnt_q[c];
         end
         if (cnt_d[c] == CNT_FULL) begin
            filt_d[c] = 1'b1;
         end else if (cnt_d[c] == CNT_ZERO) begin
            filt_d[c] = 1'b0;
         end else begin
            filt_d[c] = filt_q[c];
         end
      end
   end

   // Pulses track the level change; a latch set outranks a coincident acknowledge.
   always_comb begin
      rise_d  = filt_d & ~filt_q;
      fall_d  = ~filt_d & filt_q;
      latch_d = LATCH_MASK & (rise_d | (latch_q & ~(flt_io.fault_ack & ~filt_q)));
   end

   // Synchroniser, integrator and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= {N_CH{1'b0}};
         s2_q    <= {N_CH{1'b0}};
         filt_q  <= {N_CH{1'b0}};
         rise_q  <= {N_CH{1'b0}};
         fall_q  <= {N_CH{1'b0}};
         latch_q <= {N_CH{1'b0}};
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c] <= CNT_ZERO;
         end
      end else begin
         s1_q    <= flt_io.raw_in;
         s2_q    <= s1_q;
         filt_q  <= filt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         latch_q <= latch_d;
         for (int c = 0; c < N_CH; c++) begin
            cnt_q[c] <= cnt_d[c];
         end
      end
   end

   assign flt_io.filt_out    = filt_q;
   assign flt_io.rise_pulse  = rise_q;
   assign flt_io.fall_pulse  = fall_q;
   assign flt_io.fault_latch = latch_q;

`ifdef RPSC_FILT_GLITCH_CNT_EN
   logic [N_CH-1:0]   diff_q, diff_d;
   logic [7:0]        gcnt_q [N_CH];
   logic [7:0]        gcnt_d [N_CH];
   logic [8*N_CH-1:0] gcnt_flat_s;

   // A glitch is counted when the synchronised input comes back into agreement with the level.
   always_comb begin
      diff_d      = s2_q ^ filt_q;
      gcnt_flat_s = {(8*N_CH){1'b0}};
      for (int c = 0; c < N_CH; c++) begin
         gcnt_d[c] = gcnt_q[c];
         if (flt_io.glitch_clr) begin
            gcnt_d[c] = 8'h00;
         end else if (diff_q[c] && !diff_d[c] && (gcnt_q[c] != 8'hFF)) begin
            gcnt_d[c] = gcnt_q[c] + 8'h01;
         end else begin
            gcnt_d[c] = gcnt_q[c];
         end
         gcnt_flat_s[8*c +: 8] = gcnt_q[c];
      end
   end

   // Glitch counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         diff_q <= {N_CH{1'b0}};
         for (int c = 0; c < N_CH; c++) begin
            gcnt_q[c] <= 8'h00;
         end
      end else begin
         diff_q <= diff_d;
         for (int c = 0; c < N_CH; c++) begin
            gcnt_q[c] <= gcnt_d[c];
         end
      end
   end

   assign flt_io.glitch_cnt = gcnt_flat_s;
`endif

endmodule
